// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-core state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    localparam int CLK_FREQ_HZ = 100000000;
    localparam int BAUD        = 115200;
    localparam int CLK_PER_BIT = CLK_FREQ_HZ / BAUD;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receive core: 2-flop input synchronizer plus mid-bit sampling state machine.
// Latency: byte_valid pulses CLK_PER_BIT/2 + 9*CLK_PER_BIT cycles after IDLE sees the start bit.
// Backpressure: none; byte_valid is a single-cycle pulse the consumer must take or lose.
module uart_rx_core #(
    parameter int CLK_PER_BIT = uart_pkg::CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_tx_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err_pulse
);
    import uart_pkg::*;

    localparam int              CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]   HALF_LOAD = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   BIT_LOAD  = CW'(CLK_PER_BIT - 1);

    logic            sync1;
    logic            rxs;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;

    // Two-flop synchronizer; both stages reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_tx_in;
            rxs   <= sync1;
        end
    end

    // Frame state machine: half-bit to start-bit centre, then one full bit per sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            shreg           <= '0;
            byte_out        <= '0;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rxs) begin
                            idx   <= '0;
                            cnt   <= BIT_LOAD;
                            state <= DATA;
                        end else begin
                            // Line back high at start-bit centre: a glitch, not a frame.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg[idx] <= rxs;
                        cnt        <= BIT_LOAD;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (rxs) begin
                            byte_out   <= shreg;
                            byte_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            // Bad stop bit: drop the byte and wait out any break.
                            frame_err_pulse <= 1'b1;
                            state           <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_with_buffer.sv
// UART receiver with a show-ahead byte FIFO and sticky overflow / framing-error flags.
// Latency: a received byte is visible on rx_data/rx_valid one cycle after the core's byte_valid.
// Backpressure: rx_ready pops the head; a byte arriving into a full FIFO without a same-cycle pop is dropped.
module uart_rx_with_buffer #(
    parameter int CLK_PER_BIT = uart_pkg::CLK_PER_BIT,
    parameter int DEPTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_tx_in,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH+1)-1:0] rx_count,
    output logic                       overflow,
    output logic                       frame_error,
    input  logic                       clear_errors
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          frame_err_pulse;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          do_push;

    uart_rx_core #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_core (
        .clk             (clk),
        .rst             (rst),
        .uart_tx_in      (uart_tx_in),
        .byte_out        (byte_out),
        .byte_valid      (byte_valid),
        .frame_err_pulse (frame_err_pulse)
    );

    assign rx_valid = (rx_count != '0);
    assign rx_data  = mem[rd_ptr];
    assign full     = (rx_count == CNTW'(DEPTH));
    assign pop      = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push  = byte_valid && (!full || pop);

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= byte_out;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !pop) begin
                rx_count <= rx_count + CNTW'(1);
            end else if (!do_push && pop) begin
                rx_count <= rx_count - CNTW'(1);
            end
        end
    end

    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (byte_valid && full && !pop) begin
                overflow <= 1'b1;
            end else if (clear_errors) begin
                overflow <= 1'b0;
            end
            if (frame_err_pulse) begin
                frame_error <= 1'b1;
            end else if (clear_errors) begin
                frame_error <= 1'b0;
            end
        end
    end

endmodule
